ram_access_master: RTL and testbench
====================================

Name: ram_access_master

Overview:
- Initiator-side sequencer that drives the `ram_controller` port set: `write_en`, `read_en`, `address`, `data_in` out; `data_out` in.
- Accepts single or burst read/write commands over a valid/ready command port.
- Sequences the per-beat RAM strobes and returns read data over a valid/ready response port with backpressure.
- Sits between a host/test engine and the RAM controller; replaces hand-driven stimulus.

Parameters:
- READ_LATENCY, 1: cycles from the `mem_read_en` cycle to `mem_data_out` being valid. Legal range 1..7.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_wdata  in  DATA_W  first write data value.
- cmd_len  in  4  burst length minus 1 (beats = cmd_len+1, 1..16).
- rsp_valid  out  1  read response data valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data.
- done  out  1  one-cycle pulse when a burst completes.
- mem_write_en  out  1  to RAM controller `write_en`.
- mem_read_en  out  1  to RAM controller `read_en`.
- mem_address  out  ADDR_W  to RAM controller `address`.
- mem_data_in  out  DATA_W  to RAM controller `data_in`.
- mem_data_out  in  DATA_W  from RAM controller `data_out`.

Behaviour:
- **Reset.** Async on rst_n low. All outputs go to 0 immediately: cmd_ready, rsp_valid, rsp_rdata, done, mem_* are 0. State becomes IDLE and all counters clear. Reset mid-burst abandons the burst; no further strobes are issued. The first cycle after release is IDLE with cmd_ready=1.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.
- **States.** IDLE, WRITE, READ_REQ, READ_WAIT, RESP.
- **IDLE.**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch addr, wdata, len and write.
  - Go to WRITE if cmd_write, else READ_REQ.
  - cmd_ready drops in the cycle after acceptance.
  - Commands while not IDLE are ignored (cmd_ready=0).
- **WRITE.**
  - Asserts mem_write_en=1 for cmd_len+1 consecutive cycles, one beat per cycle.
  - Beat k drives mem_address = cmd_addr+k and mem_data_in = cmd_wdata+k, both mod 2^width (0xFF wraps to 0x00).
  - After the last beat: mem_write_en=0, done=1 for one cycle, return to IDLE. cmd_ready=1 in that same cycle.
- **READ_REQ.** mem_read_en=1 for exactly one cycle with mem_address = cmd_addr+k. Then READ_WAIT.
- **READ_WAIT.**
  - mem_read_en=0; mem_address is held.
  - A latency counter runs READ_LATENCY cycles.
  - On the clock edge ending the last wait cycle, capture mem_data_out into rsp_rdata. Go to RESP.
  - With READ_LATENCY=1: read_en high in cycle t, capture at the end of t+1, rsp_valid=1 from t+2.
- **RESP.**
  - rsp_valid=1; rsp_rdata is held stable until rsp_ready is sampled high.
  - No new read is issued while rsp_ready=0 (full backpressure).
  - On handshake: rsp_valid=0. If beats remain, k++ and go to READ_REQ. Otherwise done=1 for one cycle and go to IDLE.
- **Exclusivity.** mem_read_en and mem_write_en are never both 1.
- **Counters.** The beat counter is 4 bits and compares against the latched len. The latency counter is 3 bits.
- **Address wrap.** Applies to reads too: a burst from 0xFE with len=3 reads 0xFE, 0xFF, 0x00, 0x01.

Test Plan:
1. **Reset mid-write-burst.** Write burst addr=0x10, len=7, wdata=0x00; assert rst_n=0 at the third beat. Required: all mem_* and done go to 0 immediately; cmd_ready=1 in the first cycle after release; no further writes occur.
2. **Single write then read.** Write addr=0x01, wdata=0xFF, len=0 → one-cycle mem_write_en with address 0x01, data 0xFF, then done. Read addr=0x01, len=0 → rsp_valid two cycles after the mem_read_en cycle, rsp_rdata=0xFF.
3. **Write burst with wrap.** Write burst addr=0xFE, wdata=0xFE, len=3 → 4 consecutive write cycles: (0xFE,0xFE), (0xFF,0xFF), (0x00,0x00), (0x01,0x01); done one cycle after the last beat. Read back the same range → responses 0xFE, 0xFF, 0x00, 0x01.
4. **Response backpressure.** Read burst len=2 with rsp_ready held low 5 cycles on beat 0 → rsp_valid and rsp_rdata stable for those cycles; no mem_read_en during the stall; all 3 responses delivered in order.
5. **Command while busy.** Assert cmd_valid with a second command during a write burst → cmd_ready=0, command ignored; accepted only once IDLE resumes.
6. **READ_LATENCY=3 build.** Read addr=0x02 after writing 0xAA → capture on the 3rd edge after the read_en cycle; rsp_rdata=0xAA; no earlier sample.

Source files
------------

// File: rtl/ram_access_master.sv
// ram_access_master: command-driven sequencer for a simple single-port RAM
// controller. It accepts single or burst read/write commands on a valid/ready
// port, issues one RAM strobe per beat and returns read data on a valid/ready
// response port with full backpressure.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   cmd_*             command handshake; cmd_len is beats-1 (1..16 beats)
//   rsp_*             read response handshake
//   done              one-cycle pulse when a burst completes
//   mem_*             RAM controller strobes, address and data
// All outputs are registered.
module ram_access_master #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [3:0]        cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              done,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int unsigned LEN_W = 4;
    localparam int unsigned LAT_W = 3;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_WRITE     = 3'd1;
    localparam logic [ST_W-1:0] ST_READ_REQ  = 3'd2;
    localparam logic [ST_W-1:0] ST_READ_WAIT = 3'd3;
    localparam logic [ST_W-1:0] ST_RESP      = 3'd4;

    // Last value of the latency counter before read data is captured.
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    logic [ST_W-1:0]   state_q,  state_d;
    logic [LEN_W-1:0]  beat_q,   beat_d;
    logic [LEN_W-1:0]  len_q,    len_d;
    logic [LAT_W-1:0]  lat_q,    lat_d;

    logic              cmd_ready_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              done_d;
    logic              mem_write_en_d;
    logic              mem_read_en_d;
    logic [ADDR_W-1:0] mem_address_d;
    logic [DATA_W-1:0] mem_data_in_d;

    // State, counters and all outputs registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            len_q        <= '0;
            lat_q        <= '0;
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            done         <= 1'b0;
            mem_write_en <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_address  <= '0;
            mem_data_in  <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            lat_q        <= lat_d;
            cmd_ready    <= cmd_ready_d;
            rsp_valid    <= rsp_valid_d;
            rsp_rdata    <= rsp_rdata_d;
            done         <= done_d;
            mem_write_en <= mem_write_en_d;
            mem_read_en  <= mem_read_en_d;
            mem_address  <= mem_address_d;
            mem_data_in  <= mem_data_in_d;
        end
    end

    // Next state and next register values. mem_address and mem_data_in
    // double as the running beat address and write data.
    always_comb begin
        state_d        = state_q;
        beat_d         = beat_q;
        len_d          = len_q;
        lat_d          = lat_q;
        cmd_ready_d    = 1'b0;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = rsp_rdata;
        done_d         = 1'b0;
        mem_write_en_d = 1'b0;
        mem_read_en_d  = 1'b0;
        mem_address_d  = mem_address;
        mem_data_in_d  = mem_data_in;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d   = 1'b0;
                    len_d         = cmd_len;
                    beat_d        = '0;
                    mem_address_d = cmd_addr;
                    if (cmd_write) begin
                        state_d        = ST_WRITE;
                        mem_write_en_d = 1'b1;
                        mem_data_in_d  = cmd_wdata;
                    end else begin
                        state_d       = ST_READ_REQ;
                        mem_read_en_d = 1'b1;
                    end
                end
            end

            // One beat per cycle; the registered strobe already shows beat_q.
            ST_WRITE: begin
                if (beat_q == len_q) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    cmd_ready_d = 1'b1;
                end else begin
                    beat_d         = beat_q + LEN_W'(1);
                    mem_write_en_d = 1'b1;
                    mem_address_d  = mem_address + ADDR_W'(1);
                    mem_data_in_d  = mem_data_in + DATA_W'(1);
                end
            end

            ST_READ_REQ: begin
                state_d = ST_READ_WAIT;
                lat_d   = '0;
            end

            // Capture on the edge that ends the last wait cycle.
            ST_READ_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    rsp_rdata_d = mem_data_out;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end

            // Hold the response until the consumer takes it.
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (beat_q == len_q) begin
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                        cmd_ready_d = 1'b1;
                    end else begin
                        state_d       = ST_READ_REQ;
                        beat_d        = beat_q + LEN_W'(1);
                        mem_read_en_d = 1'b1;
                        mem_address_d = mem_address + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_access_master.sv
// Bench for ram_access_master: two instances (read latency 1 and 3), each
// with a small RAM controller model. Stimulus pushes expected writes, read
// addresses and read responses into queues; one monitor pops and compares
// whenever a DUT presents a strobe or a response.
module tb_ram_access_master;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid, cmd_valid3;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [3:0] cmd_len;
    logic       rsp_ready;

    logic       cmd_ready,    cmd_ready3;
    logic       rsp_valid,    rsp_valid3;
    logic [7:0] rsp_rdata,    rsp_rdata3;
    logic       done,         done3;
    logic       mem_write_en, mem_write_en3;
    logic       mem_read_en,  mem_read_en3;
    logic [7:0] mem_address,  mem_address3;
    logic [7:0] mem_data_in,  mem_data_in3;
    logic [7:0] mem_data_out, mem_data_out3;

    ram_access_master #(.READ_LATENCY(LAT_A), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .done(done),
        .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    ram_access_master #(.READ_LATENCY(LAT_B), .ADDR_W(8), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
        .done(done3),
        .mem_write_en(mem_write_en3), .mem_read_en(mem_read_en3),
        .mem_address(mem_address3), .mem_data_in(mem_data_in3),
        .mem_data_out(mem_data_out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM controller models: data is valid only in cycle t+LAT after a
    // read_en in cycle t; any other cycle shows 0x5A.
    logic [7:0] ram  [256];
    logic [7:0] ram3 [256];
    logic [7:0] pipe  [8];
    logic [7:0] pipe3 [8];
    logic [7:0] vld, vld3;

    always @(posedge clk) begin
        if (mem_write_en)  ram[mem_address]   <= mem_data_in;
        if (mem_write_en3) ram3[mem_address3] <= mem_data_in3;
        pipe[0]  <= ram[mem_address];
        pipe3[0] <= ram3[mem_address3];
        for (int i = 1; i < 8; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe3[i] <= pipe3[i-1];
        end
        if (!rst_n) begin
            vld  <= '0;
            vld3 <= '0;
        end else begin
            vld  <= {vld[6:0],  mem_read_en};
            vld3 <= {vld3[6:0], mem_read_en3};
        end
    end

    assign mem_data_out  = vld[LAT_A-1]  ? pipe[LAT_A-1]  : 8'h5A;
    assign mem_data_out3 = vld3[LAT_B-1] ? pipe3[LAT_B-1] : 8'h5A;

    // Scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_raddr[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  exp_raddr3[$];
    logic [7:0]  exp_rsp3[$];
    logic [7:0]  ref_mem [256];
    int cyc = 0;
    int rd_cyc = 0, rd_cyc3 = 0;
    int wr_seen = 0, rd_seen = 0;
    bit rsp_v_prev = 1'b0, rsp_v_prev3 = 1'b0;
    logic [15:0] mon_e;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every strobe and response against the queues.
    always @(negedge clk) begin
        if (!rst_n) begin
            rsp_v_prev  = 1'b0;
            rsp_v_prev3 = 1'b0;
        end else begin
            cyc++;
            if (mem_write_en || mem_read_en)
                check("strobe exclusive", int'(mem_write_en & mem_read_en), 0);
            if (mem_write_en) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    check("no write expected", int'(mem_write_en), 0);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("write addr", int'(mem_address), int'(mon_e[15:8]));
                    check("write data", int'(mem_data_in), int'(mon_e[7:0]));
                    ref_mem[mon_e[15:8]] = mon_e[7:0];
                end
            end
            if (mem_read_en) begin
                rd_seen++;
                rd_cyc = cyc;
                check("read while rsp pending", int'(rsp_valid), 0);
                if (exp_raddr.size() == 0)
                    check("no read expected", int'(mem_read_en), 0);
                else
                    check("read addr", int'(mem_address), int'(exp_raddr.pop_front()));
            end
            if (rsp_valid && !rsp_v_prev)
                check("read latency", cyc - rd_cyc, LAT_A + 1);
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    check("no rsp expected", int'(rsp_valid), 0);
                end else begin
                    check("rsp data", int'(rsp_rdata), int'(exp_rsp[0]));
                    if (rsp_ready) void'(exp_rsp.pop_front());
                end
            end
            rsp_v_prev = rsp_valid;

            if (mem_write_en3 || mem_read_en3)
                check("strobe exclusive L3", int'(mem_write_en3 & mem_read_en3), 0);
            if (mem_read_en3) begin
                rd_cyc3 = cyc;
                if (exp_raddr3.size() == 0)
                    check("no read expected L3", int'(mem_read_en3), 0);
                else
                    check("read addr L3", int'(mem_address3), int'(exp_raddr3.pop_front()));
            end
            if (rsp_valid3 && !rsp_v_prev3)
                check("read latency L3", cyc - rd_cyc3, LAT_B + 1);
            if (rsp_valid3) begin
                if (exp_rsp3.size() == 0) begin
                    check("no rsp expected L3", int'(rsp_valid3), 0);
                end else begin
                    check("rsp data L3", int'(rsp_rdata3), int'(exp_rsp3[0]));
                    if (rsp_ready) void'(exp_rsp3.pop_front());
                end
            end
            rsp_v_prev3 = rsp_valid3;
        end
    end

    task automatic push_write(input logic [7:0] a, input logic [7:0] d, input int len);
        for (int k = 0; k <= len; k++)
            exp_wr.push_back({a + 8'(k), d + 8'(k)});
    endtask

    task automatic push_read(input logic [7:0] a, input int len);
        logic [7:0] ak;
        for (int k = 0; k <= len; k++) begin
            ak = a + 8'(k);
            exp_raddr.push_back(ak);
            exp_rsp.push_back(ref_mem[ak]);
        end
    endtask

    // Present a command and return one #1 after the accepting edge.
    task automatic issue(input bit sel, input bit wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [3:0] len);
        int t;
        bit ok;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = len;
        if (sel) cmd_valid3 = 1'b1;
        else     cmd_valid  = 1'b1;
        t  = 0;
        ok = 1'b0;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = sel ? cmd_ready3 : cmd_ready;
            t++;
        end
        check("cmd accepted", int'(ok), 1);
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
    endtask

    // Wait for done; exp_n < 0 skips the cycle-count comparison.
    task automatic wait_done(input bit sel, input int exp_n);
        int n;
        n = 0;
        while (!(sel ? done3 : done) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done seen", int'(sel ? done3 : done), 1);
        if (exp_n >= 0) check("done cycle", n, exp_n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int t;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid3 = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        cmd_len    = '0;
        rsp_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset cmd_ready", int'(cmd_ready), 0);
        check("reset mem_write_en", int'(mem_write_en), 0);
        check("reset rsp_valid", int'(rsp_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("cmd_ready after reset", int'(cmd_ready), 1);

        // Reset in the middle of a write burst, during beat 2.
        push_write(8'h10, 8'h00, 7);
        issue(1'b0, 1'b1, 8'h10, 8'h00, 4'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("beat2 strobe", int'(mem_write_en), 1);
        check("beat2 addr", int'(mem_address), 8'h12);
        #1 rst_n = 1'b0;
        #1;
        check("rst mem_write_en", int'(mem_write_en), 0);
        check("rst mem_read_en", int'(mem_read_en), 0);
        check("rst mem_address", int'(mem_address), 0);
        check("rst mem_data_in", int'(mem_data_in), 0);
        check("rst done", int'(done), 0);
        check("rst cmd_ready", int'(cmd_ready), 0);
        check("beats before reset", wr_seen, 2);
        exp_wr.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("cmd_ready after mid-burst reset", int'(cmd_ready), 1);
        base = wr_seen;
        repeat (12) @(posedge clk);
        check("writes after reset", wr_seen - base, 0);
        #1;

        // Single write then single read.
        push_write(8'h01, 8'hFF, 0);
        issue(1'b0, 1'b1, 8'h01, 8'hFF, 4'd0);
        wait_done(1'b0, 1);
        push_read(8'h01, 0);
        issue(1'b0, 1'b0, 8'h01, 8'h00, 4'd0);
        wait_done(1'b0, 3);

        // Write burst across the address wrap, then read it back.
        push_write(8'hFE, 8'hFE, 3);
        issue(1'b0, 1'b1, 8'hFE, 8'hFE, 4'd3);
        wait_done(1'b0, 4);
        push_read(8'hFE, 3);
        issue(1'b0, 1'b0, 8'hFE, 8'h00, 4'd3);
        wait_done(1'b0, 12);

        // Backpressure: hold rsp_ready low for 5 cycles on beat 0.
        push_read(8'hFF, 2);
        rsp_ready = 1'b0;
        issue(1'b0, 1'b0, 8'hFF, 8'h00, 4'd2);
        t = 0;
        while (!rsp_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("stall rsp_valid", int'(rsp_valid), 1);
        base = rd_seen;
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("reads during stall", rd_seen - base, 0);
        check("rsp held", int'(rsp_valid), 1);
        rsp_ready = 1'b1;
        wait_done(1'b0, -1);

        // Second command presented while a write burst is running.
        push_write(8'h40, 8'h40, 3);
        issue(1'b0, 1'b1, 8'h40, 8'h40, 4'd3);
        push_write(8'h50, 8'h77, 0);
        cmd_addr  = 8'h50;
        cmd_wdata = 8'h77;
        cmd_len   = 4'd0;
        cmd_write = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("busy cmd_ready", int'(cmd_ready), 0);
            @(posedge clk); #1;
        end
        check("idle cmd_ready", int'(cmd_ready), 1);
        check("first burst done", int'(done), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(1'b0, 1);
        push_read(8'h42, 1);
        issue(1'b0, 1'b0, 8'h42, 8'h00, 4'd1);
        wait_done(1'b0, 6);

        // Read latency 3 instance.
        issue(1'b1, 1'b1, 8'h02, 8'hAA, 4'd0);
        wait_done(1'b1, 1);
        exp_raddr3.push_back(8'h02);
        exp_rsp3.push_back(8'hAA);
        issue(1'b1, 1'b0, 8'h02, 8'h00, 4'd0);
        wait_done(1'b1, 5);

        repeat (3) @(posedge clk);
        check("writes drained", exp_wr.size(), 0);
        check("responses drained", exp_rsp.size(), 0);
        check("responses drained L3", exp_rsp3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
